// File: rtl/dma_priority_arbiter.sv
// DMA channel request arbiter: synchronises DREQ, qualifies requests, runs the hold-request
// handshake and drives DACK. Define ROTATING_PRIORITY_EN to honour PriorityRotate (otherwise fixed priority).
module dma_priority_arbiter #(
    parameter int DREQ_SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic       DREQSense,
    input  logic       DACKSense,
    input  logic       ControllerDisable,
    input  logic       PriorityRotate,
    input  logic [3:0] MaskBits,
    input  logic [3:0] SoftRequest,
    input  logic       HLDA,
    input  logic       ServiceDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       Grant,
    output logic [1:0] ActiveChannel,
    output logic [3:0] RequestStatus
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

    state_t     state;
    logic [3:0] sync_q [DREQ_SYNC_STAGES];
    logic [3:0] eff_req;
    logic [1:0] base;
    logic [1:0] winner;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int s = 0; s < DREQ_SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= DREQ;
            for (int s = 1; s < DREQ_SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign eff_req = ControllerDisable ? 4'b0000
                   : (((sync_q[DREQ_SYNC_STAGES-1] ^ {4{DREQSense}}) & ~MaskBits) | SoftRequest);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) RequestStatus <= '0;
        else       RequestStatus <= eff_req;
    end

`ifdef ROTATING_PRIORITY_EN
    logic [1:0] ptr;

    // Pointer advances on every completed service, even one ended together with HLDA falling.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                             ptr <= 2'd0;
        else if (state == GRANT && ServiceDone) ptr <= ActiveChannel + 2'd1;
    end

    assign base = PriorityRotate ? ptr : 2'd0;
`else
    logic unused_rotate;
    assign unused_rotate = PriorityRotate;
    assign base          = 2'd0;
`endif

    // Scan from the lowest-priority slot upward so the highest-priority requester wins.
    function automatic logic [1:0] pick_first(input logic [3:0] r, input logic [1:0] b);
        logic [1:0] idx;
        pick_first = b;
        for (int k = 3; k >= 0; k--) begin
            idx = b + 2'(k);
            if (r[idx]) pick_first = idx;
        end
    endfunction

    assign winner = pick_first(eff_req, base);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            HRQ           <= 1'b0;
            Grant         <= 1'b0;
            ActiveChannel <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eff_req) begin
                        state <= REQ;
                        HRQ   <= 1'b1;
                    end
                end
                REQ: begin
                    if (HLDA && (|eff_req)) begin
                        state         <= GRANT;
                        Grant         <= 1'b1;
                        ActiveChannel <= winner;
                    end else if (!(|eff_req)) begin
                        state <= IDLE;
                        HRQ   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (ServiceDone || !HLDA) begin
                        state <= IDLE;
                        HRQ   <= 1'b0;
                        Grant <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    HRQ   <= 1'b0;
                    Grant <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        DACK = {4{~DACKSense}};
        if (Grant) DACK[ActiveChannel] = DACKSense;
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter (default DREQ_SYNC_STAGES=2).
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       DREQSense;
    logic       DACKSense;
    logic       ControllerDisable;
    logic       PriorityRotate;
    logic [3:0] MaskBits;
    logic [3:0] SoftRequest;
    logic       HLDA;
    logic       ServiceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       Grant;
    logic [1:0] ActiveChannel;
    logic [3:0] RequestStatus;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ROTATING_PRIORITY_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    dma_priority_arbiter dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .DREQSense        (DREQSense),
        .DACKSense        (DACKSense),
        .ControllerDisable(ControllerDisable),
        .PriorityRotate   (PriorityRotate),
        .MaskBits         (MaskBits),
        .SoftRequest      (SoftRequest),
        .HLDA             (HLDA),
        .ServiceDone      (ServiceDone),
        .HRQ              (HRQ),
        .DACK             (DACK),
        .Grant            (Grant),
        .ActiveChannel    (ActiveChannel),
        .RequestStatus    (RequestStatus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Mask everything while the synchroniser drains so nothing re-requests.
    task automatic quiet();
        MaskBits    = 4'hF;
        DREQ        = 4'h0;
        SoftRequest = 4'h0;
        HLDA        = 1'b0;
        ServiceDone = 1'b0;
        DREQSense   = 1'b0;
        tick(4);
        MaskBits    = 4'h0;
        chk("quiet_hrq", HRQ, 0);
    endtask

    initial begin
        RESET = 1'b1; DREQ = 4'h0; DREQSense = 1'b0; DACKSense = 1'b0;
        ControllerDisable = 1'b0; PriorityRotate = 1'b1; MaskBits = 4'h0;
        SoftRequest = 4'h0; HLDA = 1'b0; ServiceDone = 1'b0;

        #1;
        chk("rst_hrq", HRQ, 0);
        chk("rst_grant", Grant, 0);
        chk("rst_ac", ActiveChannel, 0);
        chk("rst_dack", DACK, 4'hF);
        chk("rst_rs", RequestStatus, 0);
        DACKSense = 1'b1;
        #1;
        chk("idle_dack_sense1", DACK, 4'h0);
        DACKSense = 1'b0;
        tick(1);
        RESET = 1'b0;

        // Disabled controller ignores requests
        ControllerDisable = 1'b1;
        DREQ = 4'b0001;
        tick(4);
        chk("dis_hrq", HRQ, 0);
        chk("dis_rs", RequestStatus, 0);
        ControllerDisable = 1'b0;
        quiet();

        // DREQ latency and basic grant
        DREQ = 4'b0110;
        tick(2);
        chk("t1_hrq_early", HRQ, 0);
        tick(1);
        chk("t1_hrq", HRQ, 1);
        chk("t1_rs", RequestStatus, 4'b0110);
        tick(2);
        chk("t1_hrq_wait", HRQ, 1);
        chk("t1_grant_wait", Grant, 0);
        HLDA = 1'b1;
        DREQ = 4'h0;
        tick(1);
        chk("t1_grant", Grant, 1);
        chk("t1_ac", ActiveChannel, 1);
        chk("t1_dack", DACK, 4'b1101);
        ServiceDone = 1'b1;
        tick(1);
        ServiceDone = 1'b0;
        chk("t1_done_hrq", HRQ, 0);
        chk("t1_done_grant", Grant, 0);
        chk("t1_done_dack", DACK, 4'hF);
        quiet();

        // Masked pin versus software request
        MaskBits = 4'b0001;
        DREQ = 4'b0001;
        tick(4);
        chk("t2_masked_hrq", HRQ, 0);
        chk("t2_masked_rs", RequestStatus, 0);
        SoftRequest = 4'b0001;
        tick(1);
        chk("t2_soft_hrq", HRQ, 1);
        chk("t2_soft_rs", RequestStatus, 4'b0001);
        HLDA = 1'b1;
        tick(1);
        chk("t2_ac", ActiveChannel, 0);
        chk("t2_grant", Grant, 1);
        chk("t2_dack", DACK, 4'b1110);
        ServiceDone = 1'b1;
        tick(1);
        ServiceDone = 1'b0;
        chk("t2_done_grant", Grant, 0);
        quiet();

        // HLDA abort on channel 2 must leave the pointer alone
        DREQ = 4'b0100;
        tick(3);
        chk("t3_hrq", HRQ, 1);
        HLDA = 1'b1;
        tick(1);
        chk("t3_ac", ActiveChannel, 2);
        chk("t3_dack", DACK, 4'b1011);
        HLDA = 1'b0;
        DREQ = 4'b0101;
        tick(1);
        chk("t3_abort_grant", Grant, 0);
        chk("t3_abort_hrq", HRQ, 0);
        chk("t3_abort_dack", DACK, 4'hF);
        tick(1);
        chk("t3_rereq_hrq", HRQ, 1);
        HLDA = 1'b1;
        tick(1);
        chk("t3_after_abort_ac", ActiveChannel, ROT ? 2'd2 : 2'd0);
        ServiceDone = 1'b1;
        tick(1);
        ServiceDone = 1'b0;
        quiet();

        // Inverted DREQ sense
        MaskBits = 4'hF;
        DREQSense = 1'b1;
        DREQ = 4'b1011;
        tick(3);
        chk("t4_masked_hrq", HRQ, 0);
        MaskBits = 4'h0;
        tick(1);
        chk("t4_hrq", HRQ, 1);
        chk("t4_rs", RequestStatus, 4'b0100);
        HLDA = 1'b1;
        tick(1);
        chk("t4_ac", ActiveChannel, 2);
        chk("t4_dack", DACK, 4'b1011);
        ServiceDone = 1'b1;
        tick(1);
        ServiceDone = 1'b0;
        quiet();

        // Asynchronous reset during a grant
        DREQ = 4'b1000;
        tick(3);
        HLDA = 1'b1;
        tick(1);
        chk("t5_ac", ActiveChannel, 3);
        chk("t5_grant", Grant, 1);
        #1;
        RESET = 1'b1;
        #1;
        chk("t5_rst_hrq", HRQ, 0);
        chk("t5_rst_grant", Grant, 0);
        chk("t5_rst_dack", DACK, 4'hF);
        chk("t5_rst_ac", ActiveChannel, 0);
        RESET = 1'b0;
        quiet();

        // Back-to-back services with all channels requesting
        DREQ = 4'hF;
        tick(3);
        chk("t6_hrq", HRQ, 1);
        for (int k = 0; k < 4; k++) begin
            HLDA = 1'b1;
            tick(1);
            chk("t6_rot_ac", ActiveChannel, ROT ? 2'(k) : 2'd0);
            ServiceDone = 1'b1;
            HLDA = (k % 2 == 1) ? 1'b0 : 1'b1;
            tick(1);
            ServiceDone = 1'b0;
            HLDA = 1'b0;
            chk("t6_done_grant", Grant, 0);
            tick(1);
            chk("t6_rereq_hrq", HRQ, 1);
        end
        HLDA = 1'b1;
        tick(1);
        chk("t6_wrap_ac", ActiveChannel, 0);
        ServiceDone = 1'b1;
        tick(1);
        ServiceDone = 1'b0;
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
